// File: rtl/wb_sequencer.sv
// wb_sequencer: write-back sequencer driving the register file's single
// write port from three producers (A = ALU, B = load, C = link address).
// Each producer owns a one-entry buffer; one buffered write issues per
// cycle, oldest first, ties resolved C > B > A.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   {a,b,c}_valid/addr/data/ready   per-source request handshake
//   rf_we, rf_wsel                  registered write enable and source code
//                                   (00 = A, 01 = B, 11 = C)
//   rf_waddr, rf_wdata              registered write address / data
//   pend_mask                       registers with a write buffered or on the
//                                   output port (for hazard detection)
module wb_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     b_ready,
    input  logic                     c_valid,
    input  logic [ADDR_W-1:0]        c_addr,
    input  logic [DATA_W-1:0]        c_data,
    output logic                     c_ready,
    output logic                     rf_we,
    output logic [1:0]               rf_wsel,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [(1<<ADDR_W)-1:0]   pend_mask
);

    localparam int DEPTH = 1 << ADDR_W;

    // Index 0 = A, 1 = B, 2 = C throughout.
    logic [2:0]                    in_valid;
    logic [2:0][ADDR_W-1:0]        in_addr;
    logic [2:0][DATA_W-1:0]        in_data;

    logic [2:0]                    full;
    logic [2:0][ADDR_W-1:0]        buf_addr;
    logic [2:0][DATA_W-1:0]        buf_data;
    logic [2:0][1:0]               buf_age;

    logic [2:0]                    grant;
    logic [2:0]                    ready;
    logic [1:0]                    pick;
    logic [1:0]                    best_age;
    logic                          found;

    assign in_valid = {c_valid, b_valid, a_valid};
    assign in_addr  = {c_addr, b_addr, a_addr};
    assign in_data  = {c_data, b_data, a_data};

    // Scanning A, B, C with >= lets the later (higher-priority) source win ties.
    always_comb begin
        pick     = 2'd0;
        best_age = 2'd0;
        found    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (full[i] && (!found || buf_age[i] >= best_age)) begin
                pick     = i[1:0];
                best_age = buf_age[i];
                found    = 1'b1;
            end
        end
        grant = 3'b000;
        if (found) grant[pick] = 1'b1;
    end

    assign ready   = ~full | grant;
    assign a_ready = ready[0];
    assign b_ready = ready[1];
    assign c_ready = ready[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            buf_addr <= '0;
            buf_data <= '0;
            buf_age  <= '0;
            rf_we    <= 1'b0;
            rf_wsel  <= 2'b00;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (in_valid[i] && ready[i]) begin
                    // Writes to register 0 are absorbed: handshake completes,
                    // but nothing is buffered.
                    full[i]     <= (in_addr[i] != '0);
                    buf_addr[i] <= in_addr[i];
                    buf_data[i] <= in_data[i];
                    buf_age[i]  <= 2'd0;
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end else if (full[i] && buf_age[i] != 2'd3) begin
                    buf_age[i] <= buf_age[i] + 2'd1;
                end
            end

            rf_we <= found;
            if (found) begin
                // Source code: A = 00, B = 01, C = 11.
                rf_wsel  <= {pick[1], pick[1] | pick[0]};
                rf_waddr <= buf_addr[pick];
                rf_wdata <= buf_data[pick];
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 3; i++) begin
            if (full[i]) pend_mask[buf_addr[i]] = 1'b1;
        end
        if (rf_we) pend_mask[rf_waddr] = 1'b1;
    end

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;

    typedef struct packed {
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, c_valid;
    logic [3:0]  a_addr, b_addr, c_addr;
    logic [31:0] a_data, b_data, c_data;
    logic        a_ready, b_ready, c_ready;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] pend_mask;

    int  n_cmp = 0;
    int  n_err = 0;
    wr_t exp_q[$];
    logic [31:0] last_r7;

    always #5 clk = ~clk;

    wb_sequencer #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wr_t mk(input logic [1:0] s, input logic [3:0] a, input logic [31:0] d);
        wr_t w;
        w.sel = s; w.addr = a; w.data = d;
        return w;
    endfunction

    // Monitor: every write on the port must match the head of the queue.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            wr_t got;
            got = {rf_wsel, rf_waddr, rf_wdata};
            if (rf_waddr == 4'd7) last_r7 = rf_wdata;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got %0h expected none at %0t", got, $time);
            end else begin
                chk("write", 64'(got), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_in();
        a_valid = 0; b_valid = 0; c_valid = 0;
    endtask

    initial begin
        rst = 1;
        clear_in();
        a_addr = 0; b_addr = 0; c_addr = 0;
        a_data = 0; b_data = 0; c_data = 0;
        last_r7 = 0;
        idle(2);
        chk("rst_we", 64'(rf_we), 0);
        chk("rst_wsel", 64'(rf_wsel), 0);
        chk("rst_waddr", 64'(rf_waddr), 0);
        chk("rst_wdata", 64'(rf_wdata), 0);
        chk("rst_pend", 64'(pend_mask), 0);
        rst = 0;
        idle(1);

        // Single A write, pend bit 5 set for exactly two cycles.
        a_valid = 1; a_addr = 5; a_data = 32'h1234;
        #1 chk("t1_a_ready", 64'(a_ready), 1);
        exp_q.push_back(mk(2'b00, 4'd5, 32'h1234));
        @(negedge clk); clear_in();
        chk("t1_pend0", 64'(pend_mask), 64'h0020);
        @(negedge clk);
        chk("t1_pend1", 64'(pend_mask), 64'h0020);
        chk("t1_we", 64'(rf_we), 1);
        @(negedge clk);
        chk("t1_pend2", 64'(pend_mask), 0);
        idle(1);

        // Three sources on one edge: C, B, A.
        a_valid = 1; a_addr = 1; a_data = 32'h11;
        b_valid = 1; b_addr = 2; b_data = 32'h22;
        c_valid = 1; c_addr = 3; c_data = 32'h33;
        exp_q.push_back(mk(2'b11, 4'd3, 32'h33));
        exp_q.push_back(mk(2'b01, 4'd2, 32'h22));
        exp_q.push_back(mk(2'b00, 4'd1, 32'h11));
        @(negedge clk); clear_in();
        chk("t2_a_ready0", 64'(a_ready), 0);
        chk("t2_b_ready0", 64'(b_ready), 0);
        chk("t2_pend", 64'(pend_mask), 64'h000E);
        @(negedge clk);
        chk("t2_a_ready1", 64'(a_ready), 0);
        chk("t2_b_ready1", 64'(b_ready), 1);
        @(negedge clk);
        chk("t2_a_ready2", 64'(a_ready), 1);
        idle(2);
        chk("t2_pend_end", 64'(pend_mask), 0);

        // Same register from A and C on one edge: A's value lands last.
        a_valid = 1; a_addr = 7; a_data = 32'hAAAA;
        c_valid = 1; c_addr = 7; c_data = 32'hCCCC;
        exp_q.push_back(mk(2'b11, 4'd7, 32'hCCCC));
        exp_q.push_back(mk(2'b00, 4'd7, 32'hAAAA));
        @(negedge clk); clear_in();
        idle(4);
        chk("t3_final_r7", 64'(last_r7), 64'hAAAA);

        // Streaming A: ready and rf_we held high, one write per cycle.
        for (int k = 0; k < 8; k++) begin
            a_valid = 1; a_addr = 4'(k % 15 + 1); a_data = 32'h100 + k;
            exp_q.push_back(mk(2'b00, 4'(k % 15 + 1), 32'h100 + k));
            #1 chk("t4_a_ready", 64'(a_ready), 1);
            if (k >= 2) chk("t4_we", 64'(rf_we), 1);
            @(negedge clk);
        end
        clear_in();
        chk("t4_we_tail", 64'(rf_we), 1);
        idle(3);

        // Address 0 is swallowed.
        b_valid = 1; b_addr = 0; b_data = 32'hDEAD;
        #1 chk("t5_b_ready", 64'(b_ready), 1);
        @(negedge clk); clear_in();
        for (int k = 0; k < 3; k++) begin
            chk("t5_pend", 64'(pend_mask), 0);
            chk("t5_we", 64'(rf_we), 0);
            @(negedge clk);
        end

        // Reset discards buffered B and C.
        b_valid = 1; b_addr = 4; b_data = 32'hB4;
        c_valid = 1; c_addr = 6; c_data = 32'hC6;
        @(negedge clk); clear_in();
        chk("t6_pend_loaded", 64'(pend_mask), 64'h0050);
        rst = 1;
        @(negedge clk);
        chk("t6_we", 64'(rf_we), 0);
        chk("t6_pend", 64'(pend_mask), 0);
        rst = 0;
        idle(5);

        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
